nios2_multi_timer: RTL



---
 rtl/nios2_multi_timer.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/nios2_multi_timer.sv
// Multi-channel Avalon-MM interval timer: per-channel prescaled down-counter,
// PWM compare output, counter snapshot, and a shared interrupt line.
module nios2_multi_timer #(
    parameter int NUM_CH       = 2,
    parameter int CNT_W        = 32,
    parameter int PRESC_W      = 8,
    parameter int ADDR_W       = 6,
    parameter int RESET_PERIOD = 49999
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              irq,
    output logic [NUM_CH-1:0] pwm_out
);

    localparam int CH_W = ADDR_W - 3;

    logic                     wr_en;
    logic [CH_W-1:0]          ch_sel;
    logic [2:0]               reg_sel;
    logic [NUM_CH-1:0]        pend;
    logic [NUM_CH-1:0]        pwm_d;
    logic [NUM_CH-1:0][31:0]  rd_ch;
    logic [31:0]              readdata_d;
    logic [31:0]              readdata_q;
    logic                     irq_d;
    logic                     irq_q;
    logic [NUM_CH-1:0]        pwm_q;

    assign wr_en   = chipselect & ~write_n;
    assign ch_sel  = address[ADDR_W-1:3];
    assign reg_sel = address[2:0];

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [CNT_W-1:0]   cnt_q, cnt_d, period_q, period_d;
        logic [CNT_W-1:0]   cmp_q, cmp_d, snap_q, snap_d;
        logic [PRESC_W-1:0] presc_q, presc_d, pcnt_q, pcnt_d;
        logic               ito_q, ito_d, cont_q, cont_d, pwm_en_q, pwm_en_d;
        logic               to_q, to_d, run_q, run_d;
        logic               sel, tick, timeout, start, stop;
        logic               wr_status, wr_ctrl, wr_period, wr_cmp, wr_snap, wr_presc;
        logic [31:0]        rd_val;

        assign sel       = wr_en && (ch_sel == CH_W'(gi));
        assign wr_status = sel && (reg_sel == 3'd0);
        assign wr_ctrl   = sel && (reg_sel == 3'd1);
        assign wr_period = sel && (reg_sel == 3'd2);
        assign wr_cmp    = sel && (reg_sel == 3'd3);
        assign wr_snap   = sel && (reg_sel == 3'd4);
        assign wr_presc  = sel && (reg_sel == 3'd5);
        assign start     = wr_ctrl && writedata[2];
        assign stop      = wr_ctrl && writedata[3];
        assign tick      = run_q && (pcnt_q == presc_q);
        assign timeout   = tick && (cnt_q == '0);

        // Later assignments carry priority: PERIOD write > STOP > START > timeout.
        always_comb begin
            cnt_d    = cnt_q;
            period_d = period_q;
            cmp_d    = cmp_q;
            snap_d   = snap_q;
            presc_d  = presc_q;
            pcnt_d   = pcnt_q;
            ito_d    = ito_q;
            cont_d   = cont_q;
            pwm_en_d = pwm_en_q;
            to_d     = to_q;
            run_d    = run_q;
            if (run_q) pcnt_d = tick ? '0 : pcnt_q + PRESC_W'(1);
            if (tick)  cnt_d  = (cnt_q == '0) ? period_q : cnt_q - CNT_W'(1);
            if (timeout) begin
                to_d = 1'b1;
                if (!cont_q) run_d = 1'b0;
            end else if (wr_status) begin
                to_d = 1'b0;
            end
            if (wr_ctrl) begin
                ito_d    = writedata[0];
                cont_d   = writedata[1];
                pwm_en_d = writedata[4];
                if (stop) begin
                    run_d = 1'b0;
                end else if (start) begin
                    run_d  = 1'b1;
                    pcnt_d = '0;
                end
            end
            if (wr_period) begin
                period_d = writedata[CNT_W-1:0];
                cnt_d    = writedata[CNT_W-1:0];
                run_d    = 1'b0;
                pcnt_d   = '0;
            end
            if (wr_cmp)   cmp_d   = writedata[CNT_W-1:0];
            if (wr_snap)  snap_d  = cnt_q;
            if (wr_presc) presc_d = writedata[PRESC_W-1:0];
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cnt_q    <= CNT_W'(RESET_PERIOD);
                period_q <= CNT_W'(RESET_PERIOD);
                cmp_q    <= '0;
                snap_q   <= '0;
                presc_q  <= '0;
                pcnt_q   <= '0;
                ito_q    <= 1'b0;
                cont_q   <= 1'b0;
                pwm_en_q <= 1'b0;
                to_q     <= 1'b0;
                run_q    <= 1'b0;
            end else begin
                cnt_q    <= cnt_d;
                period_q <= period_d;
                cmp_q    <= cmp_d;
                snap_q   <= snap_d;
                presc_q  <= presc_d;
                pcnt_q   <= pcnt_d;
                ito_q    <= ito_d;
                cont_q   <= cont_d;
                pwm_en_q <= pwm_en_d;
                to_q     <= to_d;
                run_q    <= run_d;
            end
        end

        always_comb begin
            rd_val = '0;
            case (reg_sel)
                3'd0:    rd_val = {30'd0, run_q, to_q};
                3'd1:    rd_val = {27'd0, pwm_en_q, 2'b00, cont_q, ito_q};
                3'd2:    rd_val = 32'(period_q);
                3'd3:    rd_val = 32'(cmp_q);
                3'd4:    rd_val = 32'(snap_q);
                3'd5:    rd_val = 32'(presc_q);
                default: rd_val = '0;
            endcase
        end

        assign rd_ch[gi] = rd_val;
        assign pend[gi]  = to_q & ito_q;
        assign pwm_d[gi] = pwm_en_q & run_q & (cnt_q < cmp_q);
    end

    // IRQ_PEND lives only at channel 0; unpopulated channels read as zero.
    always_comb begin
        readdata_d = '0;
        if (reg_sel == 3'd6) begin
            if (ch_sel == '0) readdata_d = 32'(pend);
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (ch_sel == CH_W'(c)) readdata_d = rd_ch[c];
            end
        end
    end

    assign irq_d = |pend;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata_q <= '0;
            irq_q      <= 1'b0;
            pwm_q      <= '0;
        end else begin
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
            pwm_q      <= pwm_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;
    assign pwm_out  = pwm_q;

endmodule
